enc_iterative: RTL and testbench

AES-128 encryption core, the transmit-side counterpart of the decryption pipeline. It computes one round per clock over a single shared round datapath. It uses the same round-key loading interface (rkey/addr), backed by an internal 11-entry key table. Blocks are accepted and returned with valid/ready handshakes, and it sits between the host plaintext FIFO and the ciphertext output buffer.

---
 rtl/enc_iterative.sv | 202 ++++++++++++++++++++
 tb/tb_enc_iterative.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_iterative.sv
// AES-128 iterative encryptor: one round per clock over a shared round datapath, 11-entry round-key table.
// Optional on-chip key expansion (triggered by a write to key 0) when ENC_KEY_EXPAND_EN is defined.
module enc_iterative #(
   parameter int NR         = 10,
   parameter int KEY_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [127:0]          rkey,
   input  logic [KEY_ADDR_W-1:0] addr,
   input  logic                  key_we,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          din,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          dout,
   output logic                  busy
);
   localparam logic [3:0]            LAST_RND = 4'(NR);
   localparam logic [KEY_ADDR_W-1:0] MAX_ADDR = KEY_ADDR_W'(NR);

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
`ifdef ENC_KEY_EXPAND_EN
      DONE,
      EXPAND
`else
      DONE
`endif
   } state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 by square-and-multiply; maps 0 to 0 without a special case
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
              a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
              a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
              gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)};
   endfunction

   state_t       state_reg;
   logic [3:0]   rnd_reg;
   logic [127:0] s_reg;
   logic [127:0] key [NR+1];
   logic [7:0]   sb [16];
   logic [127:0] sr, mc, round_key, round_out, key0;
   logic         key_wr;

   // byte n of the block sits at bits [127-8n -: 8], n = row + 4*column
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub_shift
         assign sb[gi] = sbox(s_reg[127-8*gi -: 8]);
         assign sr[127-8*gi -: 8] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
      end
      for (gi = 0; gi < 4; gi++) begin : g_mix
         assign mc[127-32*gi -: 32] = mix_col(sr[127-32*gi -: 32]);
      end
   endgenerate

   assign round_key = key[rnd_reg];
   assign round_out = ((rnd_reg == LAST_RND) ? sr : mc) ^ round_key;
   assign key_wr    = key_we && (state_reg == IDLE) && (addr <= MAX_ADDR);
   assign key0      = (key_wr && (addr == '0)) ? rkey : key[0];

`ifdef ENC_KEY_EXPAND_EN
   logic [31:0]  rot_w, sub_w, ex_t, n0, n1, n2, n3;
   logic [7:0]   rcon;
   logic [127:0] exp_next;

   assign rot_w = {s_reg[23:0], s_reg[31:24]};
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sub_word
         assign sub_w[31-8*gi -: 8] = sbox(rot_w[31-8*gi -: 8]);
      end
   endgenerate

   always_comb begin
      rcon = 8'h00;
      case (rnd_reg)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign ex_t     = sub_w ^ {rcon, 24'h000000};
   assign n0       = s_reg[127:96] ^ ex_t;
   assign n1       = s_reg[95:64] ^ n0;
   assign n2       = s_reg[63:32] ^ n1;
   assign n3       = s_reg[31:0] ^ n2;
   assign exp_next = {n0, n1, n2, n3};

   // a key-0 write starts expansion, so no block may be taken in that cycle
   assign in_ready = !rst && (state_reg == IDLE) && !(key_wr && (addr == '0));
`else
   assign in_ready = !rst && (state_reg == IDLE);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         rnd_reg   <= 4'd0;
         s_reg     <= '0;
         dout      <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         key       <= '{default: '0};
      end else begin
         if (key_wr) key[addr] <= rkey;
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready) begin
                  s_reg     <= din ^ key0;
                  rnd_reg   <= 4'd1;
                  state_reg <= ROUND;
                  busy      <= 1'b1;
               end
`ifdef ENC_KEY_EXPAND_EN
               else if (key_wr && (addr == '0)) begin
                  s_reg     <= rkey;
                  rnd_reg   <= 4'd1;
                  state_reg <= EXPAND;
                  busy      <= 1'b1;
               end
`endif
            end
            ROUND: begin
               s_reg <= round_out;
               if (rnd_reg == LAST_RND) begin
                  dout      <= round_out;
                  out_valid <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  rnd_reg <= rnd_reg + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
`ifdef ENC_KEY_EXPAND_EN
            EXPAND: begin
               key[rnd_reg] <= exp_next;
               s_reg        <= exp_next;
               if (rnd_reg == LAST_RND) begin
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  rnd_reg <= rnd_reg + 4'd1;
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_enc_iterative.sv
// Self-checking bench for enc_iterative: table-driven AES-128 reference model with randomized blocks and keys.
module tb_enc_iterative;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] rkey = '0;
   logic [3:0]   addr = '0;
   logic         key_we = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] din = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] dout;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox_t [256];
   logic [127:0] mk [11];

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   always #5 clk = ~clk;

   enc_iterative dut (
      .clk(clk), .rst(rst), .rkey(rkey), .addr(addr), .key_we(key_we),
      .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
   );

   // ---------------- reference model ----------------
   function automatic int rot8(input int v, input int n);
      return ((v << n) | (v >> (8 - n))) & 'hff;
   endfunction

   // S-box built by walking the multiplicative group with generator 3 and its inverse
   function automatic void build_sbox();
      int p, q, x;
      p = 1;
      q = 1;
      do begin
         p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 'hff;
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         q = q & 'hff;
         if ((q & 'h80) != 0) q = q ^ 'h09;
         x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
         sbox_t[p] = 8'(x ^ 'h63);
      end while (p != 1);
      sbox_t[0] = 8'h63;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic void expand_key(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] pt);
      logic [7:0]   st [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] k, res;
      k = mk[0];
      for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8] ^ k[127-8*n -: 8];
      for (int r = 1; r <= 10; r++) begin
         k = mk[r];
         for (int n = 0; n < 16; n++) t[n] = sbox_t[st[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < 10) begin
               st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
            end
         end
         for (int n = 0; n < 16; n++) st[n] = st[n] ^ k[127-8*n -: 8];
      end
      for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic write_key(input logic [3:0] a, input logic [127:0] v);
      @(negedge clk);
      key_we = 1'b1; addr = a; rkey = v;
      @(posedge clk); #1;
      key_we = 1'b0; addr = '0; rkey = '0;
   endtask

   // highest index first so a key-0 write (which may trigger expansion) comes last
   task automatic load_keys();
      for (int i = 10; i >= 0; i--) write_key(4'(i), mk[i]);
   endtask

   task automatic run_block(input logic [127:0] pt, output logic [127:0] ct, output int lat, output bit ok);
      int w;
      w = 0; ok = 1'b0; ct = '0; lat = 0;
      @(negedge clk);
      while (!in_ready && w < 40) begin @(negedge clk); w++; end
      if (!in_ready) return;
      din = pt; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; din = rand128();
      lat = 1;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      ct = dout; ok = out_valid;
      $display("block pt=%h ct=%h edges=%0d", pt, ct, lat);
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_fips_b();
      logic [127:0] ct; int lat; bit ok;
      expand_key(KEY_B);
      load_keys();
      run_block(PT_B, ct, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fips_b_timeout: out_valid=%b want 1", out_valid); end
      checks++; if (lat !== 11) begin errors++; $display("FAIL fips_b_latency: got %0d edges want 11", lat); end
      checks++; if (ct !== CT_B) begin errors++; $display("FAIL fips_b_dout: got %h want %h", ct, CT_B); end
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fips_b_done_flags: busy=%b in_ready=%b want 1/0", busy, in_ready); end
      handshake();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL fips_b_handshake: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_fips_c1();
      logic [127:0] ct; int lat; bit ok;
      expand_key(KEY_C);
`ifdef ENC_KEY_EXPAND_EN
      write_key(4'd0, KEY_C);
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL c1_expand_flags: busy=%b in_ready=%b want 1/0", busy, in_ready);
      end
`else
      load_keys();
`endif
      run_block(PT_C, ct, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL c1_timeout: out_valid=%b want 1", out_valid); end
      checks++; if (ct !== CT_C) begin errors++; $display("FAIL c1_dout: got %h want %h", ct, CT_C); end
      handshake();
   endtask

   task automatic test_backpressure();
      logic [127:0] pt, ct; int lat; bit ok, stable;
      pt = rand128();
      run_block(pt, ct, lat, ok);
      checks++; if (!ok || ct !== model_enc(pt)) begin errors++; $display("FAIL bp_dout: got %h want %h", ct, model_enc(pt)); end
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || dout !== ct || in_ready !== 1'b0) stable = 1'b0;
      end
      checks++; if (!stable) begin errors++; $display("FAIL bp_hold: out_valid=%b in_ready=%b dout=%h want 1/0/%h", out_valid, in_ready, dout, ct); end
      handshake();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_ready_early();
      logic [127:0] pt, ct; int lat; bit ok;
      pt = rand128();
      out_ready = 1'b1;
      run_block(pt, ct, lat, ok);
      checks++; if (!ok || lat !== 11) begin errors++; $display("FAIL early_latency: got %0d edges valid=%b want 11", lat, ok); end
      checks++; if (ct !== model_enc(pt)) begin errors++; $display("FAIL early_dout: got %h want %h", ct, model_enc(pt)); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_drop: out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_key_guard();
      logic [127:0] pt, ct; int w, lat; bit ok;
      expand_key(KEY_B);
      load_keys();
      pt = rand128();
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 40) begin @(negedge clk); w++; end
      din = pt; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      write_key(4'd3, rand128());
      w = 0;
      while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
      checks++; if (out_valid !== 1'b1 || dout !== model_enc(pt)) begin
         errors++; $display("FAIL guard_block: valid=%b got %h want %h", out_valid, dout, model_enc(pt));
      end
      handshake();
      write_key(4'd12, rand128());
      run_block(PT_B, ct, lat, ok);
      checks++; if (!ok || ct !== CT_B) begin errors++; $display("FAIL guard_rerun: got %h want %h", ct, CT_B); end
      handshake();
   endtask

   task automatic test_reset_mid();
      logic [127:0] pt, ct; int w, lat; bit ok;
      pt = rand128();
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 40) begin @(negedge clk); w++; end
      din = pt; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_flags: out_valid=%b busy=%b want 0/0", out_valid, busy); end
      checks++; if (dout !== '0) begin errors++; $display("FAIL rmid_dout: got %h want 0", dout); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_release: in_ready=%b want 1", in_ready); end
      for (int r = 0; r < 11; r++) mk[r] = '0;
      run_block(128'h0, ct, lat, ok);
      checks++; if (!ok || ct !== model_enc(128'h0)) begin errors++; $display("FAIL rmid_zero_keys: got %h want %h", ct, model_enc(128'h0)); end
      handshake();
      pt = rand128();
      run_block(pt, ct, lat, ok);
      checks++; if (!ok || ct !== model_enc(pt)) begin errors++; $display("FAIL rmid_zero_keys_rand: got %h want %h", ct, model_enc(pt)); end
      handshake();
   endtask

   task automatic test_random();
      logic [127:0] pt, ct; int lat; bit ok;
      for (int it = 0; it < 6; it++) begin
         expand_key(rand128());
         load_keys();
         pt = rand128();
         run_block(pt, ct, lat, ok);
         checks++; if (!ok || lat !== 11) begin errors++; $display("FAIL rand%0d_latency: got %0d want 11", it, lat); end
         checks++; if (ct !== model_enc(pt)) begin errors++; $display("FAIL rand%0d_dout: got %h want %h", it, ct, model_enc(pt)); end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         handshake();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_release: out_valid=%b want 0", it, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] pa, pb, ea, eb;
      logic [127:0] outs [$];
      int cyc, acc_a, acc_b, hs;
      pa = rand128(); pb = rand128();
      ea = model_enc(pa); eb = model_enc(pb);
      cyc = 0; acc_a = -1; acc_b = -1; hs = -1;
      @(negedge clk);
      din = pa; in_valid = 1'b1; out_ready = 1'b1;
      while (cyc < 60 && (acc_b < 0 || outs.size() < 2)) begin
         if (in_valid && in_ready) begin
            if (acc_a < 0) acc_a = cyc; else acc_b = cyc;
         end
         if (out_valid && out_ready) begin
            outs.push_back(dout);
            if (hs < 0) hs = cyc;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc_b >= 0) in_valid = 1'b0;
         else if (acc_a >= 0) din = pb;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      $display("b2b accept_a=%0d handshake_a=%0d accept_b=%0d outputs=%0d", acc_a, hs, acc_b, outs.size());
      checks++; if (acc_a < 0 || acc_b < 0 || hs < 0) begin
         errors++; $display("FAIL b2b_progress: accept_a=%0d accept_b=%0d handshake=%0d want all >= 0", acc_a, acc_b, hs);
      end
      checks++; if (acc_b < hs + 1) begin errors++; $display("FAIL b2b_gap: accept_b=%0d want >= %0d", acc_b, hs + 1); end
      checks++; if (outs.size() != 2) begin
         errors++; $display("FAIL b2b_count: got %0d outputs want 2", outs.size());
      end else begin
         checks++; if (outs[0] !== ea) begin errors++; $display("FAIL b2b_first: got %h want %h", outs[0], ea); end
         checks++; if (outs[1] !== eb) begin errors++; $display("FAIL b2b_second: got %h want %h", outs[1], eb); end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_b();
      test_fips_c1();
      test_backpressure();
      test_ready_early();
      test_key_guard();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
